// File: rtl/dtmf_dual_tone_gen.sv
// -----------------------------------------------------------------------------
// dtmf_dual_tone_gen
//
// DTMF dual-tone burst generator. A keypad code accepted in IDLE selects one
// row frequency and one column frequency. The block then produces both square
// waves for a fixed tone burst, stays silent for a fixed gap, and finally
// pulses done for one clock.
//
// Each tone comes from an independent divider. The divider counts 0..N-1 and
// toggles its output on the wrap, so one half period is exactly N clocks.
// N = CLK_HZ / (2 * f), truncated.
//
// Parameters
//   CLK_HZ   input clock frequency in Hz
//   TONE_MS  tone burst length in ms   (TONE_CYCLES = CLK_HZ/1000*TONE_MS >= 1)
//   GAP_MS   silent gap length in ms   (GAP_CYCLES  = CLK_HZ/1000*GAP_MS  >= 1)
//   CNT_W    divider counter width; must hold the largest half-period count
//   TMR_W    burst/gap timer width; must hold max(TONE_CYCLES, GAP_CYCLES)
//
// Ports
//   clk_1m_in    in   system clock, rising edge
//   reset_b      in   asynchronous active-low reset
//   key_in[3:0]  in   keypad code: [3:2] row index, [1:0] column index
//   key_valid    in   one-cycle request strobe, honoured only in IDLE
//   cancel       in   synchronous abort; overrides every other event
//   busy         out  high in TONE or GAP
//   tone_active  out  high in TONE only
//   row_out      out  row-tone square wave
//   col_out      out  column-tone square wave
//   dtmf_sum     out  row_out + col_out, for a 2-bit resistor DAC
//   done         out  one-cycle pulse when a burst completes normally
// -----------------------------------------------------------------------------
module dtmf_dual_tone_gen #(
  parameter int CLK_HZ  = 1_000_000,
  parameter int TONE_MS = 50,
  parameter int GAP_MS  = 50,
  parameter int CNT_W   = 16,
  parameter int TMR_W   = 24
) (
  input  logic       clk_1m_in,
  input  logic       reset_b,
  input  logic [3:0] key_in,
  input  logic       key_valid,
  input  logic       cancel,
  output logic       busy,
  output logic       tone_active,
  output logic       row_out,
  output logic       col_out,
  output logic [1:0] dtmf_sum,
  output logic       done
);

  localparam int TONE_CYCLES = CLK_HZ / 1000 * TONE_MS;
  localparam int GAP_CYCLES  = CLK_HZ / 1000 * GAP_MS;

  localparam logic [TMR_W-1:0] TONE_LAST = TMR_W'(TONE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);

  // Terminal counts (N-1) of each divider. Row group: 697/770/852/941 Hz.
  localparam logic [CNT_W-1:0] ROW0_LAST = CNT_W'(CLK_HZ / (2 * 697) - 1);
  localparam logic [CNT_W-1:0] ROW1_LAST = CNT_W'(CLK_HZ / (2 * 770) - 1);
  localparam logic [CNT_W-1:0] ROW2_LAST = CNT_W'(CLK_HZ / (2 * 852) - 1);
  localparam logic [CNT_W-1:0] ROW3_LAST = CNT_W'(CLK_HZ / (2 * 941) - 1);
  // Column group: 1209/1336/1477/1633 Hz.
  localparam logic [CNT_W-1:0] COL0_LAST = CNT_W'(CLK_HZ / (2 * 1209) - 1);
  localparam logic [CNT_W-1:0] COL1_LAST = CNT_W'(CLK_HZ / (2 * 1336) - 1);
  localparam logic [CNT_W-1:0] COL2_LAST = CNT_W'(CLK_HZ / (2 * 1477) - 1);
  localparam logic [CNT_W-1:0] COL3_LAST = CNT_W'(CLK_HZ / (2 * 1633) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TONE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       key_q, key_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             row_d, col_d;
  logic             busy_d, tone_d, done_d;
  logic [CNT_W-1:0] row_last, col_last;

  // Divider terminal counts are chosen from the latched key, so later changes
  // on key_in cannot disturb a burst that is already running.
  always_comb begin
    unique case (key_q[3:2])
      2'd0:    row_last = ROW0_LAST;
      2'd1:    row_last = ROW1_LAST;
      2'd2:    row_last = ROW2_LAST;
      default: row_last = ROW3_LAST;
    endcase
    unique case (key_q[1:0])
      2'd0:    col_last = COL0_LAST;
      2'd1:    col_last = COL1_LAST;
      2'd2:    col_last = COL2_LAST;
      default: col_last = COL3_LAST;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every variable gets a default before the case statement. Without
    // this, any path that skips an assignment would infer a latch.
    state_d   = state_q;
    key_d     = key_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    timer_d   = timer_q;
    row_d     = row_out;
    col_d     = col_out;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        row_d = 1'b0;
        col_d = 1'b0;
        if (key_valid) begin
          key_d     = key_in;
          row_cnt_d = '0;
          col_cnt_d = '0;
          timer_d   = '0;
          state_d   = S_TONE;
        end
      end

      S_TONE: begin
        timer_d = timer_q + TMR_W'(1);

        if (row_cnt_q == row_last) begin
          row_cnt_d = '0;
          row_d     = ~row_out;
        end else begin
          row_cnt_d = row_cnt_q + CNT_W'(1);
        end

        if (col_cnt_q == col_last) begin
          col_cnt_d = '0;
          col_d     = ~col_out;
        end else begin
          col_cnt_d = col_cnt_q + CNT_W'(1);
        end

        // The last tone clock overrides the dividers so the gap starts silent.
        if (timer_q == TONE_LAST) begin
          timer_d   = '0;
          row_cnt_d = '0;
          col_cnt_d = '0;
          row_d     = 1'b0;
          col_d     = 1'b0;
          state_d   = S_GAP;
        end
      end

      S_GAP: begin
        row_d   = 1'b0;
        col_d   = 1'b0;
        timer_d = timer_q + TMR_W'(1);
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        row_d   = 1'b0;
        col_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a key_valid seen in IDLE.
    // The latched key is left alone; a new request reloads it anyway.
    if (cancel) begin
      state_d   = S_IDLE;
      row_cnt_d = '0;
      col_cnt_d = '0;
      timer_d   = '0;
      row_d     = 1'b0;
      col_d     = 1'b0;
      done_d    = 1'b0;
    end

    // Status flags are decoded from the next state and then registered. This
    // lines them up with the state and makes busy fall in the same cycle that
    // done rises.
    busy_d = (state_d != S_IDLE);
    tone_d = (state_d == S_TONE);
  end

  always_ff @(posedge clk_1m_in or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      timer_q     <= '0;
      row_out     <= 1'b0;
      col_out     <= 1'b0;
      busy        <= 1'b0;
      tone_active <= 1'b0;
      done        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments. All registers update together from
      // the values they held before the edge, so their order here is irrelevant.
      state_q     <= state_d;
      key_q       <= key_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      timer_q     <= timer_d;
      row_out     <= row_d;
      col_out     <= col_d;
      busy        <= busy_d;
      tone_active <= tone_d;
      done        <= done_d;
    end
  end

  // This is a pure adder on two flop outputs, so it changes only when they do.
  assign dtmf_sum = {1'b0, row_out} + {1'b0, col_out};

endmodule
